// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and baud constants.
// Baud constants assume a 100 MHz system clock.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned CLK_HZ    = 100_000_000;
  localparam int unsigned BIT_IDX_W = 4;

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return clk_hz / baud;
  endfunction

  localparam int unsigned CPB_115200 =
    clks_per_bit(CLK_HZ, 115200);
  localparam int unsigned CPB_57600 =
    clks_per_bit(CLK_HZ, 57600);
  localparam int unsigned CPB_9600 =
    clks_per_bit(CLK_HZ, 9600);

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver bus: serial input plus the valid/ready output buffer.
// master = receiver side, slave = line driver / consumer side.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic                 DATA_IN;
  logic                 DATA_READY;
  logic [DATA_BITS-1:0] DATA_OUT;
  logic                 DATA_VALID;
  logic                 PARITY_ERR;
  logic                 FRAME_ERR;
  logic                 OVERRUN;
  logic                 CTS;
  logic                 BUSY;

  modport master (
    input  DATA_IN,
    input  DATA_READY,
    output DATA_OUT,
    output DATA_VALID,
    output PARITY_ERR,
    output FRAME_ERR,
    output OVERRUN,
    output CTS,
    output BUSY
  );

  modport slave (
    output DATA_IN,
    output DATA_READY,
    input  DATA_OUT,
    input  DATA_VALID,
    input  PARITY_ERR,
    input  FRAME_ERR,
    input  OVERRUN,
    input  CTS,
    input  BUSY
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-phase counter: pulses at mid-bit (mid=1) or full-bit,
// wrapping to zero on each pulse.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  input  logic mid,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt;

  assign tick = enable &&
    (cnt == (mid ? HALF_M1 : FULL_M1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with a one-frame output buffer,
// parity/framing error flags and overrun detection.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input logic             Clock,
  input logic             Reset,
  uart_rx_param_if.master bus
);

  localparam logic [BIT_IDX_W-1:0] LAST_DATA =
    BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_STOP =
    BIT_IDX_W'(STOP_BITS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  rx_state_t state, state_nxt;

  logic                 sync_1, sync_2, line;
  logic                 tick;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_acc, ferr_acc;
  logic                 armed, done;
  logic                 last_data, last_stop;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= bus.DATA_IN;
      sync_2 <= sync_1;
    end
  end

  assign line = sync_2;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .Clock (Clock),
    .Reset (Reset),
    .clear (state == IDLE),
    .enable(state != IDLE),
    .mid   (state == START),
    .tick  (tick)
  );

  assign last_data = (bit_idx == LAST_DATA);
  assign last_stop = (bit_idx == LAST_STOP);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // armed blocks a held-low line from re-triggering a frame
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (armed && !line) state_nxt = START;
      START:
        if (tick) state_nxt = line ? IDLE : DATA;
      DATA:
        if (tick && last_data)
          state_nxt = PAR_EN ? PARITY : STOP;
      PARITY:
        if (tick) state_nxt = STOP;
      STOP:
        if (tick && last_stop) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shreg_nxt = {line, shreg[DATA_BITS-1:1]};
    if (MSB_FIRST != 0)
      shreg_nxt = {shreg[DATA_BITS-2:0], line};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bit_idx  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      ferr_acc <= 1'b0;
      armed    <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= (state == STOP) && tick && last_stop;
      if (state == IDLE && line)
        armed <= 1'b1;
      if (state == START && tick) begin
        bit_idx  <= '0;
        par_acc  <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (state == DATA && tick) begin
        shreg   <= shreg_nxt;
        par_acc <= par_acc ^ line;
        bit_idx <= last_data ? '0 : bit_idx + 1'b1;
      end
      if (state == PARITY && tick)
        par_acc <= par_acc ^ line;
      if (state == STOP && tick) begin
        ferr_acc <= ferr_acc | ~line;
        bit_idx  <= bit_idx + 1'b1;
        if (last_stop)
          armed <= 1'b0;
      end
    end
  end

  // a completed frame loads only into an empty or draining buffer
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done) begin
        if (!valid_q || bus.DATA_READY) begin
          data_q  <= shreg;
          perr_q  <= PAR_EN && (par_acc ^ PAR_ODD);
          ferr_q  <= ferr_acc;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && bus.DATA_READY) begin
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
      end
    end
  end

  assign bus.DATA_OUT   = data_q;
  assign bus.DATA_VALID = valid_q;
  assign bus.PARITY_ERR = perr_q;
  assign bus.FRAME_ERR  = ferr_q;
  assign bus.OVERRUN    = ovr_q;
  assign bus.CTS        = ~valid_q;
  assign bus.BUSY       = (state != IDLE);

endmodule
